multicycle_ctrl: RTL and testbench

- Control sequencer for the multicycle datapath. Drives the one-hot stage strobes IF/ID/EXE/MEM/WB and the datapath write enables.
- Skips stages per instruction class and stalls on a shared instruction/data memory through a req/ready handshake.
- Detects halt, illegal opcodes and memory timeout.
- Sits between the instruction register/decoder and the PC, register file and memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 25 ++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode and state encodings for the multicycle control sequencer.
package multicycle_ctrl_pkg;

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_HALT   = 3'b111;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IF    = 3'd1,
        S_ID    = 3'd2,
        S_EXE   = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    // States that hold a request on the shared memory port until mem_ready.
    function automatic logic isWaitState(input state_t s);
        return (s == S_IF) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter shared by fetch and data accesses; flags when the wait
// has reached MEM_TIMEOUT cycles.
module multicycle_ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    logic [TOW-1:0] waitCnt_r;

    // Wait counter: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_r <= '0;
        end else if (clear) begin
            waitCnt_r <= '0;
        end else if (inc) begin
            waitCnt_r <= waitCnt_r + TOW'(1);
        end else begin
            waitCnt_r <= waitCnt_r;
        end
    end

    assign timeout = (waitCnt_r == TOW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control sequencer (IF/ID/EXE/MEM/WB).
// Optional perf counters cyc_cnt/ret_cnt under `MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW         = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [OPW-1:0] opcode,
    input  logic           branch_taken,
    input  logic           mem_ready,
    output logic           stateIF,
    output logic           stateID,
    output logic           stateEXE,
    output logic           stateMEM,
    output logic           stateWB,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           ir_we,
    output logic           pc_we,
    output logic           reg_we,
    output logic           instr_done,
    output logic           illegal,
    output logic           halted,
    output logic           fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]    cyc_cnt,
    output logic [31:0]    ret_cnt
`endif
);

    state_t         state_r;
    state_t         nextState_s;
    logic [OPW-1:0] opQ_r;
    logic           fault_r;
    logic           waiting_s;
    logic           timeout_s;
    logic           opLegal_s;

    assign waiting_s = enable && isWaitState(state_r);
    assign opLegal_s = (opcode == OPW'(OP_ALU))    || (opcode == OPW'(OP_LOAD))   ||
                       (opcode == OPW'(OP_STORE))  || (opcode == OPW'(OP_BRANCH)) ||
                       (opcode == OPW'(OP_HALT));

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TOW        (TOW)
    ) memWaitTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (waiting_s && (mem_ready || timeout_s)),
        .inc    (waiting_s && !mem_ready && !timeout_s),
        .timeout(timeout_s)
    );

    // State, latched opcode and sticky fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_RESET;
            opQ_r   <= '0;
            fault_r <= 1'b0;
        end else begin
            state_r <= nextState_s;
            opQ_r   <= (enable && state_r == S_ID) ? opcode : opQ_r;
            fault_r <= fault_r || (waiting_s && !mem_ready && timeout_s);
        end
    end

    // Next-state decode; a ready response beats a simultaneous timeout.
    always_comb begin
        nextState_s = state_r;
        if (enable) begin
            case (state_r)
                S_RESET: nextState_s = S_IF;
                S_IF: begin
                    if (mem_ready)      nextState_s = S_ID;
                    else if (timeout_s) nextState_s = S_HALT;
                    else                nextState_s = S_IF;
                end
                S_ID: begin
                    if (opcode == OPW'(OP_HALT)) nextState_s = S_HALT;
                    else if (!opLegal_s)         nextState_s = S_IF;
                    else                         nextState_s = S_EXE;
                end
                S_EXE: begin
                    if (opQ_r == OPW'(OP_ALU))                                   nextState_s = S_WB;
                    else if (opQ_r == OPW'(OP_LOAD) || opQ_r == OPW'(OP_STORE)) nextState_s = S_MEM;
                    else                                                         nextState_s = S_IF;
                end
                S_MEM: begin
                    if (mem_ready)      nextState_s = (opQ_r == OPW'(OP_LOAD)) ? S_WB : S_IF;
                    else if (timeout_s) nextState_s = S_HALT;
                    else                nextState_s = S_MEM;
                end
                S_WB:    nextState_s = S_IF;
                S_HALT:  nextState_s = S_HALT;
                default: nextState_s = S_RESET;
            endcase
        end else begin
            nextState_s = state_r;
        end
    end

    // Moore strobes and requests, plus enable-gated write/retire pulses.
    always_comb begin
        stateIF    = (state_r == S_IF);
        stateID    = (state_r == S_ID);
        stateEXE   = (state_r == S_EXE);
        stateMEM   = (state_r == S_MEM);
        stateWB    = (state_r == S_WB);
        mem_rd     = (state_r == S_IF) || (state_r == S_MEM && opQ_r == OPW'(OP_LOAD));
        mem_wr     = (state_r == S_MEM) && (opQ_r == OPW'(OP_STORE));
        halted     = (state_r == S_HALT);
        fault      = fault_r;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (enable) begin
            case (state_r)
                S_IF: begin
                    ir_we = mem_ready;
                    pc_we = mem_ready;
                end
                S_ID: begin
                    illegal    = !opLegal_s;
                    instr_done = !opLegal_s;
                end
                S_EXE: begin
                    pc_we      = (opQ_r == OPW'(OP_BRANCH)) && branch_taken;
                    instr_done = (opQ_r == OPW'(OP_BRANCH));
                end
                S_MEM: instr_done = mem_ready && (opQ_r == OPW'(OP_STORE));
                S_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    ir_we      = 1'b0;
                    pc_we      = 1'b0;
                end
            endcase
        end else begin
            ir_we      = 1'b0;
            pc_we      = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Cycle and retire counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= 32'd0;
            ret_cnt <= 32'd0;
        end else begin
            cyc_cnt <= (enable && state_r != S_RESET && state_r != S_HALT) ? cyc_cnt + 32'd1 : cyc_cnt;
            ret_cnt <= instr_done ? ret_cnt + 32'd1 : ret_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default build).
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       stateIF, stateID, stateEXE, stateMEM, stateWB;
    logic       mem_rd, mem_wr, ir_we, pc_we, reg_we, instr_done, illegal, halted, fault;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int         nCmp = 0;
    int         nErr = 0;
    logic [13:0] obsv;

    localparam logic [13:0] B_IF   = 14'h2000;
    localparam logic [13:0] B_ID   = 14'h1000;
    localparam logic [13:0] B_EXE  = 14'h0800;
    localparam logic [13:0] B_MEM  = 14'h0400;
    localparam logic [13:0] B_WB   = 14'h0200;
    localparam logic [13:0] B_RD   = 14'h0100;
    localparam logic [13:0] B_WR   = 14'h0080;
    localparam logic [13:0] B_IRWE = 14'h0040;
    localparam logic [13:0] B_PCWE = 14'h0020;
    localparam logic [13:0] B_REGW = 14'h0010;
    localparam logic [13:0] B_DONE = 14'h0008;
    localparam logic [13:0] B_ILL  = 14'h0004;
    localparam logic [13:0] B_HALT = 14'h0002;
    localparam logic [13:0] B_FLT  = 14'h0001;
    localparam logic [13:0] E_NONE = 14'h0000;
    localparam logic [13:0] E_FTCH = B_IF | B_RD | B_IRWE | B_PCWE;
    localparam logic [13:0] E_FWT  = B_IF | B_RD;
    localparam logic [13:0] E_WB   = B_WB | B_REGW | B_DONE;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stateIF(stateIF), .stateID(stateID), .stateEXE(stateEXE),
        .stateMEM(stateMEM), .stateWB(stateWB), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .instr_done(instr_done),
        .illegal(illegal), .halted(halted), .fault(fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] packOut();
        return {stateIF, stateID, stateEXE, stateMEM, stateWB, mem_rd, mem_wr,
                ir_we, pc_we, reg_we, instr_done, illegal, halted, fault};
    endfunction

    // One cycle: drive inputs just after a falling edge, sample 1 time unit later.
    task automatic step(input logic en, input logic rdy, input logic [2:0] op, input logic br);
        enable = en; mem_ready = rdy; opcode = op; branch_taken = br;
        #1;
        obsv = packOut();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 1'b1, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_NONE) begin nErr++; $display("FAIL reset_state: got %h expected %h", obsv, E_NONE); end
    endtask

    task automatic test_alu();
        logic [13:0] ex [6];
        ex = '{E_NONE, E_FTCH, B_ID, B_EXE, E_WB, E_FTCH};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, OP_ALU, 1'b0);
            nCmp++;
            if (obsv !== ex[i]) begin nErr++; $display("FAIL alu[%0d]: got %h expected %h", i, obsv, ex[i]); end
        end
    endtask

    task automatic test_load_store();
        logic [13:0] exL [10];
        logic        rdL [10];
        logic [13:0] exS [8];
        logic        rdS [8];
        exL = '{E_NONE, E_FTCH, B_ID, B_EXE, B_MEM|B_RD, B_MEM|B_RD, B_MEM|B_RD, B_MEM|B_RD, E_WB, E_FTCH};
        rdL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rdL[i], OP_LOAD, 1'b0);
            nCmp++;
            if (obsv !== exL[i]) begin nErr++; $display("FAIL load[%0d]: got %h expected %h", i, obsv, exL[i]); end
        end
        exS = '{E_NONE, E_FTCH, B_ID, B_EXE, B_MEM|B_WR, B_MEM|B_WR, B_MEM|B_WR|B_DONE, E_FTCH};
        rdS = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rdS[i], OP_STORE, 1'b0);
            nCmp++;
            if (obsv !== exS[i]) begin nErr++; $display("FAIL store[%0d]: got %h expected %h", i, obsv, exS[i]); end
        end
    endtask

    task automatic test_branch();
        logic [13:0] ex [8];
        logic        br [8];
        ex = '{E_NONE, E_FTCH, B_ID, B_EXE|B_PCWE|B_DONE, E_FTCH, B_ID, B_EXE|B_DONE, E_FTCH};
        br = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, OP_BRANCH, br[i]);
            nCmp++;
            if (obsv !== ex[i]) begin nErr++; $display("FAIL branch[%0d]: got %h expected %h", i, obsv, ex[i]); end
        end
    endtask

    task automatic test_illegal_halt();
        logic [13:0] ex [6];
        logic [2:0]  op [6];
        ex = '{E_NONE, E_FTCH, B_ID|B_ILL|B_DONE, E_FTCH, B_ID|B_ILL|B_DONE, E_FTCH};
        op = '{3'b101, 3'b101, 3'b101, 3'b110, 3'b110, 3'b110};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, op[i], 1'b0);
            nCmp++;
            if (obsv !== ex[i]) begin nErr++; $display("FAIL illegal[%0d]: got %h expected %h", i, obsv, ex[i]); end
        end
        do_reset();
        step(1'b1, 1'b1, OP_HALT, 1'b0);
        step(1'b1, 1'b1, OP_HALT, 1'b0);
        step(1'b1, 1'b1, OP_HALT, 1'b0);
        nCmp++;
        if (obsv !== B_ID) begin nErr++; $display("FAIL halt_id: got %h expected %h", obsv, B_ID); end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, OP_HALT, 1'b0);
            nCmp++;
            if (obsv !== B_HALT) begin nErr++; $display("FAIL halt_hold[%0d]: got %h expected %h", i, obsv, B_HALT); end
        end
        do_reset();
        step(1'b1, 1'b1, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_NONE) begin nErr++; $display("FAIL halt_cleared: got %h expected %h", obsv, E_NONE); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1, 1'b0, OP_ALU, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, OP_ALU, 1'b0);
            nCmp++;
            if (obsv !== E_FWT) begin nErr++; $display("FAIL to_wait[%0d]: got %h expected %h", i, obsv, E_FWT); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, OP_ALU, 1'b0);
            nCmp++;
            if (obsv !== (B_HALT|B_FLT)) begin nErr++; $display("FAIL to_fault[%0d]: got %h expected %h", i, obsv, B_HALT|B_FLT); end
        end
        do_reset();
        step(1'b1, 1'b0, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_NONE) begin nErr++; $display("FAIL fault_cleared: got %h expected %h", obsv, E_NONE); end
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, OP_ALU, 1'b0);
        step(1'b1, 1'b1, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_FTCH) begin nErr++; $display("FAIL to_late_ready: got %h expected %h", obsv, E_FTCH); end
        step(1'b1, 1'b1, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== B_ID) begin nErr++; $display("FAIL to_no_fault: got %h expected %h", obsv, B_ID); end
    endtask

    task automatic test_freeze_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, OP_STORE, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, OP_STORE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, OP_STORE, 1'b0);
            nCmp++;
            if (obsv !== (B_MEM|B_WR)) begin nErr++; $display("FAIL freeze[%0d]: got %h expected %h", i, obsv, B_MEM|B_WR); end
        end
        do_reset();
        step(1'b0, 1'b0, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_NONE) begin nErr++; $display("FAIL freeze_reset: got %h expected %h", obsv, E_NONE); end
        step(1'b1, 1'b0, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== E_NONE) begin nErr++; $display("FAIL freeze_reset_en: got %h expected %h", obsv, E_NONE); end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, OP_ALU, 1'b0);
            nCmp++;
            if (obsv !== E_FWT) begin nErr++; $display("FAIL freeze_if[%0d]: got %h expected %h", i, obsv, E_FWT); end
        end
        step(1'b1, 1'b0, OP_ALU, 1'b0);
        nCmp++;
        if (obsv !== (B_HALT|B_FLT)) begin nErr++; $display("FAIL freeze_cnt_cleared: got %h expected %h", obsv, B_HALT|B_FLT); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal_halt();
        test_timeout();
        test_freeze_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
